muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the GPR file in the execute stage:
  - takes the two GPR read ports as operands (rs_data/rt_data);
  - hi/lo feed back into the GPR write-data mux for MFHI/MFLO.
- Implements MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- busy stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iterative latency is WIDTH+1 cycles.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  operation request, sampled on rising clk
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- rs_data  input  WIDTH  operand A / dividend / MTHI-MTLO source
- rt_data  input  WIDTH  operand B / divisor
- busy  output  1  high while a mult/div is in progress
- done  output  1  one-cycle pulse when HI/LO are updated by a mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst==0 at a rising edge):
  - hi=0, lo=0, busy=0, done=0, FSM to IDLE, iteration counter cleared.
  - Overrides everything else, including an operation in flight, which is aborted with no done pulse.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1:
  - op MULT/MULTU/DIV/DIVU:
    - Latch operand magnitudes; for signed ops, take the absolute value and record the result signs.
    - Counter=0, go to CALC, busy=1 from this edge.
  - op MTHI: hi<=rs_data at this edge. MTLO: lo<=rs_data at this edge.
    - busy stays 0, no done pulse.
  - op 11x: ignored.
- CALC: one iteration per cycle, WIDTH iterations; after the iteration with counter==WIDTH-1, go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX:
  - Apply sign correction and write hi/lo.
  - Go to IDLE with busy=0; done=1 for exactly this one cycle.
- Latency:
  - Start sampled at edge 0; busy high after edges 0..32.
  - hi/lo valid, busy=0 and done=1 after edge 33 (WIDTH+1).
- hi/lo hold their old values throughout CALC; no partial results are visible.
- start while busy=1: ignored entirely, including MTHI/MTLO; operands are not re-latched.
- Multiply: {hi,lo} = full 2*WIDTH product; signed for MULT, unsigned for MULTU.
- Divide: lo = quotient, hi = remainder.
  - Quotient is truncated toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): full latency retained; hi = rs_data, lo = all ones.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- rs_data/rt_data may change freely after the start edge.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational multiplier.
  - Start edge latches the product; state FIX follows directly; hi/lo written at the next edge.
  - busy high for 1 cycle; done pulses one cycle later.
  - Divide is unchanged (WIDTH+1 cycles).
- Not defined: all multiplies are iterative with WIDTH+1 latency.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=0x00000003:
  - busy high 33 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, single done pulse.
- DIVU 100/7 gives lo=14, hi=2.
  - DIV rs=0xFFFFFFF9 (-7), rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 gives hi=5, lo=0xFFFFFFFF after 33 cycles.
  - DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- During a MULT, pulse start with op=MTHI rs=0x1234 and with op=DIVU: both ignored, original MULT result lands.
  - Then MTLO rs=0xABCD while idle: lo=0xABCD next edge, busy stays 0, no done.
- MTHI 0x55 first; then start DIVU and drive rst=0 at iteration 10.
  - Next edge: busy=0, hi=lo=0, no done pulse.
  - A new MULTU 3*4 afterwards gives hi=0, lo=12.
- With MULDIV_FAST_MUL_EN, MULTU 0xFFFFFFFF*0xFFFFFFFF:
  - busy high 1 cycle, then hi=0xFFFFFFFE, lo=0x00000001.
  - DIVU 100/7 still takes 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Handles MULT, MULTU, DIV and DIVU in WIDTH+1 cycles (shift-add multiply,
// restoring divide), and MTHI/MTLO as single-edge register writes.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// multiplier and finish in two cycles; divides are unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  // Low half starts as |A| (multiplier / dividend); high half accumulates
  // the product's upper bits or the partial remainder.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;        // |B|: multiplicand / divisor magnitude
  logic [WIDTH-1:0]   dvd;        // raw dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_lo;     // negate product / quotient
  logic               neg_hi;     // negate remainder (dividend sign)
  logic               div_zero;

  // Operation decode at the request edge
  logic             md_req;
  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign md_req = start && !op[2];
  assign sgn    = !op[0];
  assign abs_a  = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign abs_b  = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Per-iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_nxt;

  // One shift-add or one restoring-divide step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH])
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Final sign correction and divide-by-zero override
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  // Produce the architectural HI/LO values from the finished accumulator
  always_comb begin
    prod   = neg_lo ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = dvd;
        fix_lo = '1;
      end else begin
        fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; requests are only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (md_req) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = op[1] ? CALC : FIX;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand capture, iteration, HI/LO writeback and done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      dvd      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (md_req) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, abs_a};
            opb      <= abs_b;
            dvd      <= rs_data;
            is_div   <= op[1];
            neg_lo   <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_hi   <= sgn && rs_data[WIDTH-1];
            div_zero <= (rt_data == '0);
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1])
              acc <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif
          end else if (start && op == OP_MTHI) begin
            hi <= rs_data;
          end else if (start && op == OP_MTLO) begin
            lo <= rs_data;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  logic         clk, rst, start;
  logic [2:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the operands after the start edge and
  // count the cycles busy stays high (bounded).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                    input logic [W-1:0] b, input int lat,
                    input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc;
    run_op(o, a, b, cyc);
    check({tag, " busy_cycles"}, cyc, lat);
    check({tag, " done"}, done, 1'b1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    @(negedge clk);
    check({tag, " done_single"}, done, 1'b0);
  endtask

  // Single-edge register write (MTHI/MTLO/no-op), checked #1 after the edge
  task automatic reg_op(input logic [2:0] o, input logic [W-1:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a;
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; op = 3'b111; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst = 1'b1;

    md("mult_neg",  MULT,  32'hFFFF_FFFE, 32'h0000_0003, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    md("divu_100_7", DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
    md("div_m7_2",  DIV,   32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md("divu_by0",  DIVU,  32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFF_FFFF);
    md("div_by0_neg", DIV, 32'hFFFF_FFFB, 32'd0, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    md("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);
    md("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    md("div_7_m2",  DIV,   32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD);

    // Requests during a long operation are dropped; HI/LO hold until the end.
    @(negedge clk);
    start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
    op = DIVU; rs_data = 32'd1000; rt_data = 32'd3;
`else
    op = MULT; rs_data = 32'h10; rt_data = 32'h20;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ign mid_hi", hi, 32'd1);
    check("ign mid_lo", lo, 32'hFFFF_FFFD);
    start = 1'b1; op = MTHI; rs_data = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("ign busy_bound", cyc < 200, 1'b1);
    check("ign done", done, 1'b1);
`ifdef MULDIV_FAST_MUL_EN
    check("ign hi", hi, 32'd1);
    check("ign lo", lo, 32'd333);
`else
    check("ign hi", hi, 32'd0);
    check("ign lo", lo, 32'h200);
`endif
    @(negedge clk);
    check("ign busy_after", busy, 1'b0);

    reg_op(MTLO, 32'hABCD);
    check("mtlo lo", lo, 32'hABCD);
    check("mtlo busy", busy, 1'b0);
    check("mtlo done", done, 1'b0);
    @(negedge clk);
    check("mtlo done_later", done, 1'b0);

    reg_op(3'b110, 32'hDEAD_BEEF);
    check("nop lo", lo, 32'hABCD);
    check("nop busy", busy, 1'b0);

    // Reset mid-divide aborts without a done pulse
    reg_op(MTHI, 32'h55);
    check("mthi hi", hi, 32'h55);
    check("mthi busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy_before", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort busy", busy, 1'b0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", done, 1'b0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort no_done", done, 1'b0);
    end

    md("multu_3_4", MULTU, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12);
    md("divu_after", DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
